// File: rtl/grant_pkg.sv
// Shared types and defaults for the grant return path.
// Contents:
//   WIDTH_DEF / TIMEOUT_DEF : default requestor count and grant hold limit, common
//                             to the encoder side and the dispatcher
//   disp_state_e            : dispatcher FSM states
package grant_pkg;

    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } disp_state_e;

endpackage

// File: rtl/idx_to_onehot.sv
// Combinational index-to-one-hot decode. This is the exact inverse of the LSB-priority
// encoder's index output.
// Ports:
//   i_idx      in   SIZE   encoded index
//   o_onehot   out  WIDTH  one-hot decode; all zero when i_idx is out of range
//   o_in_range out  1      i_idx < WIDTH
module idx_to_onehot
    import grant_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SIZE  = $clog2(WIDTH)
) (
    input  logic [SIZE-1:0]  i_idx,
    output logic [WIDTH-1:0] o_onehot,
    output logic             o_in_range
);

    always_comb begin
        o_onehot = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            o_onehot[i] = (32'(i_idx) == i);
        end
        o_in_range = (32'(i_idx) < WIDTH);
    end

endmodule

// File: rtl/enc_grant_dispatcher.sv
// Grant dispatcher. Turns an encoded grant index into a registered one-hot grant,
// holds it until the owner returns Done or a timeout revokes it, and reports events.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   GntVld/GntIdx/GntRdy encoded grant handshake (transfer = GntVld & GntRdy)
//   Gnt                 registered one-hot grant
//   Done                per-requestor release, sampled only while granted
//   DoneVld/TimeoutVld  release / revoke pulses, EvtIdx carries the owner index
//   IdxErr              accepted index out of range
//   SpuriousErr         Done seen from a non-owner while granted
module enc_grant_dispatcher
    import grant_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SIZE    = $clog2(WIDTH),
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             GntVld,
    input  logic [SIZE-1:0]  GntIdx,
    output logic             GntRdy,
    output logic [WIDTH-1:0] Gnt,
    input  logic [WIDTH-1:0] Done,
    output logic             DoneVld,
    output logic             TimeoutVld,
    output logic [SIZE-1:0]  EvtIdx,
    output logic             IdxErr,
    output logic             SpuriousErr
);

    disp_state_e      r_state;
    disp_state_e      w_state_d;
    logic [SIZE-1:0]  r_idx;
    logic [TO_W-1:0]  r_cnt;
    logic [WIDTH-1:0] r_gnt;
    logic             r_done_vld;
    logic             r_to_vld;
    logic [SIZE-1:0]  r_evt_idx;
    logic             r_idx_err;
    logic             r_spur;

    logic [WIDTH-1:0] w_onehot;
    logic             w_in_range;
    logic             w_xfer;
    logic             w_done_hit;
    logic             w_spur;
    logic             w_timeout;

    idx_to_onehot #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_dec (
        .i_idx      (GntIdx),
        .o_onehot   (w_onehot),
        .o_in_range (w_in_range)
    );

    // r_gnt is the one-hot of r_idx while in GRANT, so masking Done with it selects
    // the owner's bit and its complement selects every other requestor.
    assign w_xfer     = GntVld & (r_state == IDLE);
    assign w_done_hit = |(Done & r_gnt);
    assign w_spur     = |(Done & ~r_gnt);
    assign w_timeout  = (r_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (w_xfer && w_in_range) w_state_d = GRANT;
            GRANT:   if (w_done_hit || w_timeout) w_state_d = DRAIN;
            DRAIN:   w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_done_vld <= 1'b0;
            r_to_vld   <= 1'b0;
            r_evt_idx  <= '0;
            r_idx_err  <= 1'b0;
            r_spur     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_done_vld <= 1'b0;
            r_to_vld   <= 1'b0;
            r_idx_err  <= 1'b0;
            r_spur     <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        if (w_in_range) begin
                            r_idx <= GntIdx;
                            r_cnt <= '0;
                            r_gnt <= w_onehot;
                        end else begin
                            r_idx_err <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    r_spur <= w_spur;
                    if (w_done_hit) begin
                        // Done wins over a coincident timeout.
                        r_gnt      <= '0;
                        r_done_vld <= 1'b1;
                        r_evt_idx  <= r_idx;
                    end else if (w_timeout) begin
                        r_gnt     <= '0;
                        r_to_vld  <= 1'b1;
                        r_evt_idx <= r_idx;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                DRAIN: begin
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign GntRdy      = (r_state == IDLE);
    assign Gnt         = r_gnt;
    assign DoneVld     = r_done_vld;
    assign TimeoutVld  = r_to_vld;
    assign EvtIdx      = r_evt_idx;
    assign IdxErr      = r_idx_err;
    assign SpuriousErr = r_spur;

endmodule

// File: tb/tb_enc_grant_dispatcher.sv
module tb_enc_grant_dispatcher;

    localparam int W  = 8;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main instance, WIDTH=8.
    logic       gnt_vld = 1'b0;
    logic [2:0] gnt_idx = '0;
    logic       gnt_rdy;
    logic [7:0] gnt;
    logic [7:0] done    = '0;
    logic       done_vld, to_vld, idx_err, spur;
    logic [2:0] evt_idx;

    // Secondary instance, WIDTH=6, for out-of-range indices.
    logic       vld6  = 1'b0;
    logic [2:0] idx6  = '0;
    logic       rdy6;
    logic [5:0] gnt6;
    logic [5:0] done6 = '0;
    logic       dv6, tv6, ie6, se6;
    logic [2:0] evt6;

    int n_total = 0;
    int n_bad   = 0;

    enc_grant_dispatcher #(.WIDTH(8), .TIMEOUT(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .GntVld      (gnt_vld),
        .GntIdx      (gnt_idx),
        .GntRdy      (gnt_rdy),
        .Gnt         (gnt),
        .Done        (done),
        .DoneVld     (done_vld),
        .TimeoutVld  (to_vld),
        .EvtIdx      (evt_idx),
        .IdxErr      (idx_err),
        .SpuriousErr (spur)
    );

    enc_grant_dispatcher #(.WIDTH(6), .TIMEOUT(16)) u_dut6 (
        .clk         (clk),
        .rst_n       (rst_n),
        .GntVld      (vld6),
        .GntIdx      (idx6),
        .GntRdy      (rdy6),
        .Gnt         (gnt6),
        .Done        (done6),
        .DoneVld     (dv6),
        .TimeoutVld  (tv6),
        .EvtIdx      (evt6),
        .IdxErr      (ie6),
        .SpuriousErr (se6)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner = requestor holding the grant (-1 if none), age = cycles
    // the grant has been visible, cool = one dead cycle after a release.
    int m_owner = -1;
    int m_age   = 0;
    bit m_cool  = 1'b0;
    bit m_dv    = 1'b0;
    bit m_tv    = 1'b0;
    bit m_ie    = 1'b0;
    bit m_se    = 1'b0;
    int m_evt   = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int o, a, ev;
        bit c, dv, tv, ie, se;
        if (!rst_n) begin
            m_owner <= -1;
            m_age   <= 0;
            m_cool  <= 1'b0;
            m_dv    <= 1'b0;
            m_tv    <= 1'b0;
            m_ie    <= 1'b0;
            m_se    <= 1'b0;
            m_evt   <= 0;
        end else begin
            o = m_owner; a = m_age; c = m_cool; ev = m_evt;
            dv = 0; tv = 0; ie = 0; se = 0;
            if (o >= 0) begin
                se = (done & ~(8'd1 << o)) != 8'd0;
                if (done[3'(o)]) begin
                    dv = 1; ev = o; o = -1; c = 1;
                end else if (a == TO) begin
                    tv = 1; ev = o; o = -1; c = 1;
                end else begin
                    a = a + 1;
                end
            end else if (c) begin
                c = 0;
            end else if (gnt_vld) begin
                if (int'(gnt_idx) < W) begin
                    o = int'(gnt_idx); a = 1;
                end else begin
                    ie = 1;
                end
            end
            m_owner <= o; m_age <= a; m_cool <= c; m_evt <= ev;
            m_dv <= dv; m_tv <= tv; m_ie <= ie; m_se <= se;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic [7:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        check("onehot0_w6", 32'($onehot0(gnt6)), 32'd1);
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("gnt_rdy", 32'(gnt_rdy), 32'(m_owner < 0 && !m_cool));
        check("done_vld", 32'(done_vld), 32'(m_dv));
        check("timeout_vld", 32'(to_vld), 32'(m_tv));
        check("idx_err", 32'(idx_err), 32'(m_ie));
        check("spurious", 32'(spur), 32'(m_se));
        if (m_dv || m_tv) check("evt_idx", 32'(evt_idx), 32'(m_evt));
    end

    task automatic cyc(input logic v, input logic [2:0] idx, input logic [7:0] d);
        gnt_vld = v;
        gnt_idx = idx;
        done    = d;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rd;
    int         r;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_evt", 32'(evt_idx), 32'd0);
        check("rst_pulses", 32'({done_vld, to_vld, idx_err, spur}), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_rdy", 32'(gnt_rdy), 32'd1);

        // Basic grant and release by Done at cycle 4.
        cyc(1'b1, 3'd3, 8'h00);
        check("t1_gnt", 32'(gnt), 32'h08);
        check("t1_rdy1", 32'(gnt_rdy), 32'd0);
        cyc(1'b0, 3'd0, 8'h00);
        check("t1_rdy2", 32'(gnt_rdy), 32'd0);
        cyc(1'b0, 3'd0, 8'h00);
        cyc(1'b0, 3'd0, 8'h00);
        cyc(1'b0, 3'd0, 8'h08);
        check("t1_dv", 32'(done_vld), 32'd1);
        check("t1_evt", 32'(evt_idx), 32'd3);
        check("t1_gnt0", 32'(gnt), 32'd0);
        check("t1_drain_rdy", 32'(gnt_rdy), 32'd0);
        cyc(1'b0, 3'd0, 8'h00);
        check("t1_rdy6", 32'(gnt_rdy), 32'd1);

        // Timeout: grant held exactly 16 cycles.
        cyc(1'b1, 3'd0, 8'h00);
        check("t2_gnt", 32'(gnt), 32'h01);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 3'd0, 8'h00);
            check("t2_hold", 32'(gnt), 32'h01);
            check("t2_no_to", 32'(to_vld), 32'd0);
        end
        cyc(1'b0, 3'd0, 8'h00);
        check("t2_tv", 32'(to_vld), 32'd1);
        check("t2_evt", 32'(evt_idx), 32'd0);
        check("t2_gnt0", 32'(gnt), 32'd0);
        cyc(1'b0, 3'd0, 8'h00);

        // Done coincident with timeout: Done wins.
        cyc(1'b1, 3'd5, 8'h00);
        for (int i = 1; i < 16; i++) cyc(1'b0, 3'd0, 8'h00);
        cyc(1'b0, 3'd0, 8'h20);
        check("t3_dv", 32'(done_vld), 32'd1);
        check("t3_tv", 32'(to_vld), 32'd0);
        check("t3_evt", 32'(evt_idx), 32'd5);
        cyc(1'b0, 3'd0, 8'h00);

        // Spurious Done from a non-owner.
        cyc(1'b1, 3'd2, 8'h00);
        cyc(1'b0, 3'd0, 8'h10);
        check("t4_spur", 32'(spur), 32'd1);
        check("t4_gnt", 32'(gnt), 32'h04);
        cyc(1'b0, 3'd0, 8'h00);
        check("t4_spur_off", 32'(spur), 32'd0);
        cyc(1'b0, 3'd0, 8'h04);
        check("t4_dv", 32'(done_vld), 32'd1);
        check("t4_evt", 32'(evt_idx), 32'd2);
        cyc(1'b0, 3'd0, 8'h00);

        // WIDTH=6: out-of-range index, then an in-range grant.
        vld6 = 1'b1; idx6 = 3'd7;
        @(posedge clk); #1;
        vld6 = 1'b0;
        check("t6_ie", 32'(ie6), 32'd1);
        check("t6_gnt", 32'(gnt6), 32'd0);
        check("t6_rdy", 32'(rdy6), 32'd1);
        @(posedge clk); #1;
        check("t6_ie_off", 32'(ie6), 32'd0);
        vld6 = 1'b1; idx6 = 3'd5;
        @(posedge clk); #1;
        vld6 = 1'b0;
        check("t6_gnt5", 32'(gnt6), 32'h20);
        done6 = 6'h20;
        @(posedge clk); #1;
        done6 = '0;
        check("t6_dv", 32'(dv6), 32'd1);
        check("t6_evt", 32'(evt6), 32'd5);
        @(posedge clk); #1;

        // Random traffic with occasional reset while a grant is held.
        for (int k = 0; k < 1500; k++) begin
            if (gnt != 8'd0 && $urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_gnt", 32'(gnt), 32'd0);
                check("rst_mid_pulses", 32'({done_vld, to_vld}), 32'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            r = int'($urandom_range(0, 9));
            if (r < 2)       rd = gnt;
            else if (r < 4)  rd = 8'd1 << $urandom_range(0, 7);
            else if (r == 4) rd = 8'($urandom);
            else             rd = 8'd0;
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rd);
        end
        cyc(1'b0, 3'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
